// File: rtl/if_stage.sv
// IF stage: holds the fetch PC, drives the synchronous instruction SRAM and
// hands {pred_PC, inst, PC} to IPD. Optional macro IF_STATIC_PRED_EN enables static branch prediction.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [32:0] ID_to_IF_bus,
  output logic [95:0] IF_to_IPD_bus,
  input  logic        IPD_allow_in,
  output logic        IF_to_IPD_valid,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        r_if_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic        r_inst_buf_valid;

  logic        w_cancel;
  logic [31:0] w_pc_from_id;
  logic        w_allow_in;
  logic        w_fetch;
  logic [31:0] w_inst;
  logic [31:0] w_pred_pc;
  logic [31:0] w_next_pc;

  assign w_cancel     = ID_to_IF_bus[32];
  assign w_pc_from_id = ID_to_IF_bus[31:0];

  assign w_allow_in = ~r_if_valid | IPD_allow_in | w_cancel;
  assign w_fetch    = w_allow_in & ~reset;

  // The SRAM only holds its output while requested, so a stalled word is replayed from the buffer.
  assign w_inst = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;

`ifdef IF_STATIC_PRED_EN
  logic [5:0] w_op;
  logic       w_is_jmp;
  logic       w_is_bcc_back;

  assign w_op          = w_inst[31:26];
  assign w_is_jmp      = (w_op == 6'b010100) | (w_op == 6'b010101);
  assign w_is_bcc_back = (w_op >= 6'b010110) & (w_op <= 6'b011011) & w_inst[25];

  // b/bl always taken; conditional branches predicted taken only when backward.
  always_comb begin
    w_pred_pc = r_pc + 32'd4;
    if (w_is_jmp)
      w_pred_pc = r_pc + {{4{w_inst[9]}}, w_inst[9:0], w_inst[25:10], 2'b00};
    else if (w_is_bcc_back)
      w_pred_pc = r_pc + {{14{w_inst[25]}}, w_inst[25:10], 2'b00};
  end
`else
  assign w_pred_pc = r_pc + 32'd4;
`endif

  always_comb begin
    w_next_pc = RESET_PC;
    if (w_cancel)
      w_next_pc = w_pc_from_id;
    else if (r_if_valid)
      w_next_pc = w_pred_pc;
  end

  assign IF_to_IPD_valid = r_if_valid & ~w_cancel & ~reset;
  assign IF_to_IPD_bus   = {w_pred_pc, w_inst, r_pc};

  assign inst_sram_en    = w_fetch;
  assign inst_sram_addr  = reset ? RESET_PC : w_next_pc;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid       <= 1'b0;
      r_pc             <= RESET_PC - 32'd4;
      r_inst_buf       <= 32'd0;
      r_inst_buf_valid <= 1'b0;
    end else if (w_allow_in) begin
      r_if_valid       <= 1'b1;
      r_pc             <= w_next_pc;
      r_inst_buf_valid <= 1'b0;
    end else if (!r_inst_buf_valid) begin
      // Not allowed in implies valid, IPD stalled and no redirect: capture once.
      r_inst_buf       <= inst_sram_rdata;
      r_inst_buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall buffering, redirects,
// PC wrap and (macro-dependent) static prediction, against a small SRAM model.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] ID_to_IF_bus;
  logic [95:0] IF_to_IPD_bus;
  logic        IPD_allow_in;
  logic        IF_to_IPD_valid;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'd0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .ID_to_IF_bus(ID_to_IF_bus),
    .IF_to_IPD_bus(IF_to_IPD_bus), .IPD_allow_in(IPD_allow_in),
    .IF_to_IPD_valid(IF_to_IPD_valid), .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h1C00_0020) return {6'b010111, 16'hFFFC, 10'h000};  // bne, offs -4
    if (a == 32'h1C00_0030) return {6'b010100, 16'h0010, 10'h000};  // b, offs 0x10
    return {6'b000000, a[25:0]};
  endfunction

  // Synchronous SRAM; output is garbage whenever not requested.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    inst_sram_rdata <= inst_sram_en ? inst_of(inst_sram_addr) : (32'hBAD0_0000 | cyc);
  end

  wire [31:0] b_pc   = IF_to_IPD_bus[31:0];
  wire [31:0] b_inst = IF_to_IPD_bus[63:32];
  wire [31:0] b_pred = IF_to_IPD_bus[95:64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    ID_to_IF_bus = {1'b1, tgt}; #1;
  endtask

  task automatic no_redirect;
    ID_to_IF_bus = 33'd0; #1;
  endtask

  logic [31:0] stalled_inst;

  initial begin
    reset = 1'b1; IPD_allow_in = 1'b1; ID_to_IF_bus = 33'd0;
    repeat (3) tick;
    #1;
    chk("rst_valid", {31'd0, IF_to_IPD_valid}, 32'd0);
    chk("rst_en",    {31'd0, inst_sram_en}, 32'd0);
    chk("rst_addr",  inst_sram_addr, RST_PC);
    chk("rst_pc",    b_pc, RST_PC - 32'd4);
    chk("rst_pred",  b_pred, RST_PC);
    chk("tied_we",   {28'd0, inst_sram_we}, 32'd0);
    chk("tied_wd",   inst_sram_wdata, 32'd0);

    reset = 1'b0; #1;
    chk("first_en",   {31'd0, inst_sram_en}, 32'd1);
    chk("first_addr", inst_sram_addr, RST_PC);

    for (int i = 0; i < 3; i++) begin
      tick; #1;
      chk("stream_valid", {31'd0, IF_to_IPD_valid}, 32'd1);
      chk("stream_pc",    b_pc, RST_PC + 32'(4 * i));
      chk("stream_inst",  b_inst, inst_of(RST_PC + 32'(4 * i)));
      chk("stream_addr",  inst_sram_addr, RST_PC + 32'(4 * i + 4));
    end

    // Stall at PC=..08 while SRAM output turns to garbage.
    IPD_allow_in = 1'b0; #1;
    chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick; #1;
      chk("stall_valid", {31'd0, IF_to_IPD_valid}, 32'd1);
      chk("stall_pc",    b_pc, 32'h1C00_0008);
      chk("stall_inst",  b_inst, inst_of(32'h1C00_0008));
      chk("stall_en2",   {31'd0, inst_sram_en}, 32'd0);
    end
    IPD_allow_in = 1'b1; #1;
    chk("release_addr", inst_sram_addr, 32'h1C00_000C);
    tick; #1;
    chk("release_pc",   b_pc, 32'h1C00_000C);
    chk("release_inst", b_inst, inst_of(32'h1C00_000C));

    // Redirect while streaming.
    redirect(32'h1C00_0100);
    chk("cxl_valid", {31'd0, IF_to_IPD_valid}, 32'd0);
    chk("cxl_en",    {31'd0, inst_sram_en}, 32'd1);
    chk("cxl_addr",  inst_sram_addr, 32'h1C00_0100);
    tick; no_redirect;
    chk("cxl_pc",    b_pc, 32'h1C00_0100);
    chk("cxl_vld1",  {31'd0, IF_to_IPD_valid}, 32'd1);
    chk("cxl_inst",  b_inst, inst_of(32'h1C00_0100));

    // Redirect during an IPD stall: buffered word must be discarded.
    IPD_allow_in = 1'b0; #1;
    tick;
    stalled_inst = inst_of(32'h1C00_0100);
    chk("sc_buf", b_inst, stalled_inst);
    redirect(32'h1C00_0200);
    chk("sc_valid", {31'd0, IF_to_IPD_valid}, 32'd0);
    chk("sc_addr",  inst_sram_addr, 32'h1C00_0200);
    chk("sc_en",    {31'd0, inst_sram_en}, 32'd1);
    tick; no_redirect;
    chk("sc_pc",    b_pc, 32'h1C00_0200);
    chk("sc_vld1",  {31'd0, IF_to_IPD_valid}, 32'd1);
    chk("sc_inst",  b_inst, inst_of(32'h1C00_0200));
    tick; #1;
    chk("sc_hold",  b_inst, inst_of(32'h1C00_0200));
    IPD_allow_in = 1'b1; #1;

    // Back-to-back redirects: latest target wins.
    redirect(32'h1C00_0300);
    chk("b2b_addr0", inst_sram_addr, 32'h1C00_0300);
    tick; redirect(32'h1C00_0400);
    chk("b2b_valid", {31'd0, IF_to_IPD_valid}, 32'd0);
    chk("b2b_addr1", inst_sram_addr, 32'h1C00_0400);
    tick; no_redirect;
    chk("b2b_pc",   b_pc, 32'h1C00_0400);
    chk("b2b_inst", b_inst, inst_of(32'h1C00_0400));

    // PC wrap.
    redirect(32'hFFFF_FFFC);
    tick; no_redirect;
    chk("wrap_pc",   b_pc, 32'hFFFF_FFFC);
    chk("wrap_pred", b_pred, 32'h0000_0000);
    chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
    tick; #1;
    chk("wrap_pc2",  b_pc, 32'h0000_0000);

    // Branch predecode (bne backward, then b forward).
    redirect(32'h1C00_0020);
    tick; no_redirect;
    chk("bne_pc", b_pc, 32'h1C00_0020);
`ifdef IF_STATIC_PRED_EN
    chk("bne_pred", b_pred, 32'h1C00_0010);
    chk("bne_addr", inst_sram_addr, 32'h1C00_0010);
`else
    chk("bne_pred", b_pred, 32'h1C00_0024);
    chk("bne_addr", inst_sram_addr, 32'h1C00_0024);
`endif
    redirect(32'h1C00_0030);
    tick; no_redirect;
`ifdef IF_STATIC_PRED_EN
    chk("b_pred", b_pred, 32'h1C00_0070);
    chk("b_addr", inst_sram_addr, 32'h1C00_0070);
`else
    chk("b_pred", b_pred, 32'h1C00_0034);
    chk("b_addr", inst_sram_addr, 32'h1C00_0034);
`endif

    // Reset in the middle of a stall.
    IPD_allow_in = 1'b0; #1;
    tick;
    reset = 1'b1; #1;
    chk("mrst_valid", {31'd0, IF_to_IPD_valid}, 32'd0);
    chk("mrst_en",    {31'd0, inst_sram_en}, 32'd0);
    chk("mrst_addr",  inst_sram_addr, RST_PC);
    tick;
    reset = 1'b0; IPD_allow_in = 1'b1; #1;
    chk("mrst_en2",   {31'd0, inst_sram_en}, 32'd1);
    chk("mrst_addr2", inst_sram_addr, RST_PC);
    tick; #1;
    chk("mrst_pc",    b_pc, RST_PC);
    chk("mrst_inst",  b_inst, inst_of(RST_PC));
    chk("mrst_vld",   {31'd0, IF_to_IPD_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
